// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_e;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} pairs between fetch and decode.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wr_instr,
    input  logic [W-1:0]             wr_pc,
    output logic [W-1:0]             head_instr,
    output logic [W-1:0]             head_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  instr_mem [DEPTH];
    logic [W-1:0]  pc_mem    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO may still accept a push when the head leaves the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < FULL) || do_pop);

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            instr_mem[wr_ptr] <= wr_instr;
            pc_mem[wr_ptr]    <= wr_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one request in flight and
// buffers returned instructions toward decode, squashing stale responses.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] pc_out4
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [W-1:0] STEP = W'(INSTR_BYTES);

    fetch_state_e  state, state_n;
    logic [W-1:0]  fetch_pc, fetch_pc_n;
    logic [W-1:0]  issued_pc, issued_pc_n;
    logic          inflight, inflight_n;
    logic          squash, squash_n;

    logic          push;
    logic          pop;
    logic          flush;
    logic          credit;
    logic          resp;
    logic [W-1:0]  target;
    logic [CW-1:0] count;
    logic [W-1:0]  head_instr;
    logic [W-1:0]  head_pc;

    // The outstanding request reserves a slot so a full FIFO never overflows.
    assign credit = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign resp   = imem_rvalid && inflight;
    assign target = redirect_pc & ~W'(3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
            squash    <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            issued_pc <= issued_pc_n;
            inflight  <= inflight_n;
            squash    <= squash_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        issued_pc_n = issued_pc;
        inflight_n  = inflight;
        squash_n    = squash;
        imem_req    = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        if (redirect && state != IDLE) begin
            flush      = 1'b1;
            fetch_pc_n = target;
            if (state == WAIT || state == DRAIN) begin
                if (resp) begin
                    state_n    = REQ;
                    inflight_n = 1'b0;
                    squash_n   = 1'b0;
                end else begin
                    state_n  = DRAIN;
                    squash_n = 1'b1;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger)  state_n    = REQ;
                    if (redirect) fetch_pc_n = target;
                end
                REQ: begin
                    imem_req = credit;
                    if (credit && imem_ready) begin
                        state_n     = WAIT;
                        issued_pc_n = fetch_pc;
                        fetch_pc_n  = fetch_pc + STEP;
                        inflight_n  = 1'b1;
                    end
                end
                WAIT, DRAIN: begin
                    if (resp) begin
                        push       = !squash;
                        state_n    = REQ;
                        inflight_n = 1'b0;
                        squash_n   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wr_instr   (imem_rdata),
        .wr_pc      (issued_pc),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count)
    );

    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && !stall;
    assign Instr       = instr_valid ? head_instr : '0;
    assign pc_out      = instr_valid ? head_pc : '0;
    assign pc_out4     = pc_out + STEP;

endmodule
